signed_number_32_bit_seq_multiplier: RTL and testbench
======================================================

// Module: signed_number_32_bit_seq_multiplier
// PURPOSE
//  Multi-cycle signed (two's-complement) multiplier for the ALU; the counterpart of the signed divider.
//  Radix-2 Booth, one iteration per clock, full-width product; start/busy/done handshake to ALU control.
//  Operands are captured on accept, so the caller may change the inputs while the block is busy.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk           in   1        rising-edge clock; only clock
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        request; sampled only in IDLE
//  multiplicand  in   WIDTH    signed operand A; captured on accept
//  multiplier    in   WIDTH    signed operand B; captured on accept
//  busy          out  1        high in CALC
//  done          out  1        one-cycle pulse; product valid
//  product       out  2*WIDTH  signed A*B; held until next done
//  overflow      out  1        only with SIGNED_MUL_OVF_FLAG_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, product=0, overflow=0; counter and accumulator cleared.
//  FSM: IDLE -(start)-> CALC -(32nd iteration)-> DONE -(always)-> IDLE.
//  Accept edge: in IDLE with start=1. Latch A sign-extended to WIDTH+1 bits; clear acc; load {B,q-1=0}; count=0.
//  CALC: one Booth step per edge, on pair {q0,q-1}:
//    01 -> acc += A; 10 -> acc -= A; 00/11 -> no op.
//    Then arithmetic-shift {acc,q,q-1} right by 1.
//  acc is WIDTH+1 bits, so -2^31 operands never overflow internally.
//  32nd CALC edge: product <= {acc[WIDTH-1:0], q}; done <= 1; state -> DONE.
//  Latency: done is high in the cycle after the 32nd edge following the accept edge.
//  DONE: done <= 0 on next edge; start is ignored; state returns to IDLE.
//  Throughput: with start held high, one op every 34 cycles.
//  start in CALC/DONE: ignored, no queuing; inputs changing while busy have no effect.
//  product/overflow change only at done; they keep the previous result through the next CALC.
//  Reset mid-CALC aborts the op; no done pulse; outputs return to reset values.
// CONFIGURATION
//  SIGNED_MUL_OVF_FLAG_EN defined:
//    overflow port exists.
//    overflow registered with product.
//    overflow = 1 iff product[63:31] is not all-equal, i.e. result does not fit signed 32 bits.
//  SIGNED_MUL_OVF_FLAG_EN undefined: no overflow port, no flag logic; all else identical.
// STRUCTURE
//  Package signed_mul_pkg:
//    state enum {S_IDLE, S_CALC, S_DONE} (2 bits).
//    MUL_WIDTH=32; CNT_W=$clog2(MUL_WIDTH).
//    Booth op encoding {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB}.
//  Sub-module booth_radix2_step (combinational): in acc, q, q-1, A; out next acc, q, q-1.
//  Top holds FSM, counter, operand/product registers.
// TESTING
//  Signs: 7 * -3 -> done after 33 cycles; product=0xFFFF_FFFF_FFFF_FFEB; overflow=0.
//  Max positive: 0x7FFF_FFFF * 0x7FFF_FFFF -> product=0x3FFF_FFFF_0000_0001; overflow=1.
//  Most negative: 0x8000_0000 * 0x8000_0000 -> product=0x4000_0000_0000_0000; overflow=1.
//  Neg*pos: 0x8000_0000 * 1 -> product=0xFFFF_FFFF_8000_0000; overflow=0.
//  Busy: start pulses and operand changes during CALC (0*5 in flight) -> one done, product=0, busy low only after.
//  Reset and restart:
//    rst asserted at iteration 10 of 100*-100 -> immediate zeros, no done.
//    Then start 100*-100 -> product=0xFFFF_FFFF_FFFF_D8F0.
//  Back-to-back: start held high across ops -> done pulses exactly 34 cycles apart.

Source files
------------

// File: rtl/signed_mul_pkg.sv
// signed_mul_pkg: shared widths, FSM states and Booth op encoding for the signed multiplier
package signed_mul_pkg;
  localparam int MUL_WIDTH = 32;
  localparam int CNT_W = $clog2(MUL_WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_e;
  function automatic booth_op_e booth_op(input logic q0, input logic qm1);
    return ({q0, qm1} == 2'b01) ? BOOTH_ADD : ({q0, qm1} == 2'b10) ? BOOTH_SUB : BOOTH_NOP;
  endfunction
endpackage

// File: rtl/signed_number_32_bit_seq_multiplier_if.sv
// signed_number_32_bit_seq_multiplier_if: start/busy/done handshake bus; overflow only with SIGNED_MUL_OVF_FLAG_EN
interface signed_number_32_bit_seq_multiplier_if
  import signed_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);
  logic start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
`ifdef SIGNED_MUL_OVF_FLAG_EN
  logic overflow;
  modport master (output start, multiplicand, multiplier, input busy, done, product, overflow);
  modport slave (input start, multiplicand, multiplier, output busy, done, product, overflow);
`else
  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave (input start, multiplicand, multiplier, output busy, done, product);
`endif
endinterface

// File: rtl/booth_radix2_step.sv
// booth_radix2_step: one combinational radix-2 Booth iteration (add/sub then arithmetic shift right)
module booth_radix2_step
  import signed_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qm1,
  input  logic [WIDTH:0]   a,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n,
  output logic             qm1_n
);
  booth_op_e op;
  logic [WIDTH:0] sum;
  assign op = booth_op(q[0], qm1);
  assign sum = (op == BOOTH_ADD) ? acc + a : (op == BOOTH_SUB) ? acc - a : acc;
  assign acc_n = {sum[WIDTH], sum[WIDTH:1]};
  assign q_n = {sum[0], q[WIDTH-1:1]};
  assign qm1_n = q[0];
endmodule

// File: rtl/signed_number_32_bit_seq_multiplier.sv
// signed_number_32_bit_seq_multiplier: multi-cycle radix-2 Booth signed multiplier; SIGNED_MUL_OVF_FLAG_EN adds overflow flag
module signed_number_32_bit_seq_multiplier
  import signed_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic clk,
  input logic rst,
  signed_number_32_bit_seq_multiplier_if.slave bus
);
  state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] a, acc, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic qm1, qm1_n, last;
  logic [2*WIDTH-1:0] product_n;
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign product_n = {acc_n[WIDTH-1:0], q_n};
  assign bus.busy = state == S_CALC;
  assign bus.done = state == S_DONE;
  booth_radix2_step #(.WIDTH(WIDTH)) step (
    .acc(acc), .q(q), .qm1(qm1), .a(a),
    .acc_n(acc_n), .q_n(q_n), .qm1_n(qm1_n)
  );
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  // Next state: start is only looked at in IDLE, DONE always falls back to IDLE
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE) ? (bus.start ? S_CALC : S_IDLE) :
              (state == S_CALC) ? (last ? S_DONE : S_CALC) : S_IDLE;
  end
  // Operand capture on accept, one Booth step per CALC cycle, result latched on the last step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= '0;
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      bus.product <= '0;
    end else if (state == S_IDLE && bus.start) begin
      a <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
      acc <= '0;
      q <= bus.multiplier;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_n;
      q <= q_n;
      qm1 <= qm1_n;
      cnt <= cnt + 1'b1;
      if (last) bus.product <= product_n;
    end
`ifdef SIGNED_MUL_OVF_FLAG_EN
  // Overflow: upper half plus the sign bit of the low word must all agree to fit in WIDTH bits
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.overflow <= 1'b0;
    else if (state == S_CALC && last)
      bus.overflow <= !((&product_n[2*WIDTH-1:WIDTH-1]) || !(|product_n[2*WIDTH-1:WIDTH-1]));
`endif
endmodule

// File: tb/tb_signed_number_32_bit_seq_multiplier.sv
// tb_signed_number_32_bit_seq_multiplier: directed vectors with hand-computed products; checks SIGNED_MUL_OVF_FLAG_EN flag when defined
module tb_signed_number_32_bit_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int cyc, dones, t0, t1;
  logic early_low;
  always #5 clk = ~clk;
  signed_number_32_bit_seq_multiplier_if bus ();
  signed_number_32_bit_seq_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input logic eovf);
    int c = 0;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    do begin
      @(negedge clk);
      c++;
      bus.start = 1'b0;
    end while (!bus.done && c < 100);
    check({tag, " latency"}, 64'(c), 64'd33);
    check({tag, " product"}, bus.product, exp);
`ifdef SIGNED_MUL_OVF_FLAG_EN
    check({tag, " overflow"}, 64'(bus.overflow), 64'(eovf));
`else
    if (eovf === 1'bz) $display("note: %s", tag);
`endif
    @(negedge clk);
    check({tag, " done pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset product", bus.product, 64'd0);
    check("reset busy/done", {62'b0, bus.done, bus.busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run("7*-3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
    run("mostneg", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    run("neg*pos", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    bus.start = 1'b1;
    bus.multiplicand = 32'd100;
    bus.multiplier = -32'sd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy before rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort product", bus.product, 64'd0);
    check("abort busy/done", {62'b0, bus.done, bus.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run("100*-100", 32'd100, -32'sd100, 64'hFFFF_FFFF_FFFF_D8F0, 1'b0);
    bus.start = 1'b1;
    bus.multiplicand = 32'd0;
    bus.multiplier = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    early_low = 1'b0;
    for (int i = 2; i <= 60; i++) begin
      bus.start = (i < 25) && (i % 3 == 0);
      bus.multiplicand = 32'd7 + 32'(i);
      bus.multiplier = 32'hFFFF_FFFD;
      @(negedge clk);
      if (i < 33 && !bus.busy) early_low = 1'b1;
      if (i == 10) check("held product", bus.product, 64'hFFFF_FFFF_FFFF_D8F0);
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    check("busy held", 64'(early_low), 64'd0);
    check("busy one done", 64'(dones), 64'd1);
    check("busy product", bus.product, 64'd0);
    bus.start = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier = 32'hFFFF_FFFD;
    dones = 0;
    t0 = 0;
    t1 = 0;
    cyc = 0;
    while (dones < 2 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 1) t0 = cyc;
        else t1 = cyc;
      end
    end
    bus.start = 1'b0;
    check("b2b two dones", 64'(dones), 64'd2);
    check("b2b spacing", 64'(t1 - t0), 64'd34);
    check("b2b product", bus.product, 64'hFFFF_FFFF_FFFF_FFEB);
    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
